prefetch_queue: RTL and testbench

Parametrised instruction prefetch queue for the fetch stage. It replaces the single-byte fetch path with a circular byte buffer that instruction memory fills FETCH_BYTES at a time. It presents a window of up to MAX_INST_BYTES bytes to the translate stage, which consumes a variable number of bytes per instruction. NUM_REDIRECT prioritised redirect channels (e.g. T, D, M stage jumps) flush the buffer and restart fetch at a new PC and mode.

---
 rtl/prefetch_queue.sv | 139 +++++++++++++
 tb/tb_prefetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: a circular byte buffer filled from instruction memory
// FETCH_BYTES at a time, presenting a window of up to MAX_INST_BYTES bytes to translate.
module prefetch_queue #(
    parameter int          FETCH_BYTES    = 1,
    parameter int          DEPTH          = 16,
    parameter int          MAX_INST_BYTES = 6,
    parameter int          NUM_REDIRECT   = 3,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic [31:0]                            instmem_addr,
    input  logic [8*FETCH_BYTES-1:0]               instmem_dataout,
    input  logic [NUM_REDIRECT-1:0]                redirect_valid,
    input  logic [32*NUM_REDIRECT-1:0]             redirect_pc,
    input  logic [NUM_REDIRECT-1:0]                redirect_mode,
    input  logic                                   consume,
    input  logic [$clog2(MAX_INST_BYTES+1)-1:0]    consume_len,
    output logic [8*MAX_INST_BYTES-1:0]            out_bytes,
    output logic [$clog2(MAX_INST_BYTES+1)-1:0]    out_count,
    output logic [31:0]                            out_pc,
    output logic                                   out_mode,
    output logic                                   consume_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LEN_W = $clog2(MAX_INST_BYTES + 1);

    logic [7:0]       buf_mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [31:0]      head_pc_reg, head_pc_next;
    logic             mode_reg, mode_next;

    logic             redir_any;
    logic [31:0]      redir_pc_win;
    logic             redir_mode_win;
    logic [CNT_W-1:0] free_space;
    logic             fill;
    logic             len_ok;
    logic             consume_legal;

    // Later channels overwrite earlier ones, so the highest valid index wins.
    always_comb begin
        redir_any      = 1'b0;
        redir_pc_win   = 32'h0;
        redir_mode_win = 1'b0;
        for (int i = 0; i < NUM_REDIRECT; i++) begin
            if (redirect_valid[i]) begin
                redir_any      = 1'b1;
                redir_pc_win   = redirect_pc[32*i +: 32];
                redir_mode_win = redirect_mode[i];
            end
        end
    end

    // Fill decision uses occupancy before this cycle's consume, so space freed
    // by a consume is only reused on the following cycle.
    assign free_space = CNT_W'(DEPTH) - count_reg;
    assign fill       = !redir_any && (free_space >= CNT_W'(FETCH_BYTES));

    assign len_ok        = (consume_len != '0) && (consume_len <= out_count);
    assign consume_legal = consume && !redir_any && len_ok;
    assign consume_err   = consume && !redir_any && !len_ok;

    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        fetch_pc_next = fetch_pc_reg;
        head_pc_next  = head_pc_reg;
        mode_next     = mode_reg;
        if (redir_any) begin
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
            fetch_pc_next = redir_pc_win;
            head_pc_next  = redir_pc_win;
            mode_next     = redir_mode_win;
        end else begin
            if (consume_legal) begin
                rd_ptr_next  = rd_ptr_reg + PTR_W'(consume_len);
                head_pc_next = head_pc_reg + 32'(consume_len);
            end
            if (fill) begin
                wr_ptr_next   = wr_ptr_reg + PTR_W'(FETCH_BYTES);
                fetch_pc_next = fetch_pc_reg + 32'(FETCH_BYTES);
            end
            count_next = count_reg
                       - (consume_legal ? CNT_W'(consume_len) : CNT_W'(0))
                       + (fill ? CNT_W'(FETCH_BYTES) : CNT_W'(0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            fetch_pc_reg <= RESET_PC;
            head_pc_reg  <= RESET_PC;
            mode_reg     <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            fetch_pc_reg <= fetch_pc_next;
            head_pc_reg  <= head_pc_next;
            mode_reg     <= mode_next;
        end
    end

    // Byte storage carries no reset; stale contents are masked by count.
    always_ff @(posedge clk) begin
        if (fill && !reset) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                buf_mem_reg[wr_ptr_reg + PTR_W'(k)] <= instmem_dataout[8*k +: 8];
            end
        end
    end

    assign instmem_addr = fetch_pc_reg;
    assign out_pc       = head_pc_reg;
    assign out_mode     = mode_reg;
    assign out_count    = (count_reg >= CNT_W'(MAX_INST_BYTES)) ? LEN_W'(MAX_INST_BYTES)
                                                                : LEN_W'(count_reg);

    generate
        for (genvar gi = 0; gi < MAX_INST_BYTES; gi++) begin : g_window
            logic [PTR_W-1:0] win_idx;
            assign win_idx = rd_ptr_reg + PTR_W'(gi);
            assign out_bytes[8*gi +: 8] = (CNT_W'(gi) < count_reg) ? buf_mem_reg[win_idx] : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: one instance with 1-byte fetch, one with 4-byte fetch.
module tb_prefetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: FETCH_BYTES = 1
    logic [31:0] a_addr;
    logic [7:0]  a_data;
    logic [2:0]  a_rvalid;
    logic [95:0] a_rpc;
    logic [2:0]  a_rmode;
    logic        a_consume;
    logic [2:0]  a_len;
    logic [47:0] a_bytes;
    logic [2:0]  a_count;
    logic [31:0] a_pc;
    logic        a_mode;
    logic        a_err;

    // Instance B: FETCH_BYTES = 4
    logic [31:0] b_addr;
    logic [31:0] b_data;
    logic [2:0]  b_rvalid;
    logic [95:0] b_rpc;
    logic [2:0]  b_rmode;
    logic        b_consume;
    logic [2:0]  b_len;
    logic [47:0] b_bytes;
    logic [2:0]  b_count;
    logic [31:0] b_pc;
    logic        b_mode;
    logic        b_err;

    // Instruction memory model: byte at address a holds a[7:0].
    assign a_data = a_addr[7:0];
    always_comb begin
        b_data = '0;
        for (int k = 0; k < 4; k++) begin
            b_data[8*k +: 8] = 8'(b_addr + 32'(k));
        end
    end

    prefetch_queue #(.FETCH_BYTES(1), .DEPTH(16), .MAX_INST_BYTES(6),
                     .NUM_REDIRECT(3), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .reset(reset), .instmem_addr(a_addr), .instmem_dataout(a_data),
        .redirect_valid(a_rvalid), .redirect_pc(a_rpc), .redirect_mode(a_rmode),
        .consume(a_consume), .consume_len(a_len), .out_bytes(a_bytes),
        .out_count(a_count), .out_pc(a_pc), .out_mode(a_mode), .consume_err(a_err)
    );

    prefetch_queue #(.FETCH_BYTES(4), .DEPTH(16), .MAX_INST_BYTES(6),
                     .NUM_REDIRECT(3), .RESET_PC(32'h0)) dut_b (
        .clk(clk), .reset(reset), .instmem_addr(b_addr), .instmem_dataout(b_data),
        .redirect_valid(b_rvalid), .redirect_pc(b_rpc), .redirect_mode(b_rmode),
        .consume(b_consume), .consume_len(b_len), .out_bytes(b_bytes),
        .out_count(b_count), .out_pc(b_pc), .out_mode(b_mode), .consume_err(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s = %0h", tag, obs);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] head;
    logic [47:0] exp_win;

    initial begin
        reset     = 1'b1;
        a_rvalid  = '0; a_rpc = '0; a_rmode = '0; a_consume = 1'b0; a_len = '0;
        b_rvalid  = '0; b_rpc = '0; b_rmode = '0; b_consume = 1'b0; b_len = '0;
        tick(2);

        // Reset state
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_bytes", 64'(a_bytes), 64'h0);
        check("rst_pc",    64'(a_pc),    64'h0);
        check("rst_mode",  64'(a_mode),  64'd0);
        check("rst_addr",  64'(a_addr),  64'h0);
        check("rst_err",   64'(a_err),   64'd0);
        reset = 1'b0;

        // Three fills, no consume
        tick(3);
        check("fill3_count", 64'(a_count), 64'd3);
        check("fill3_bytes", 64'(a_bytes), 64'h000000020100);
        check("fill3_addr",  64'(a_addr),  64'd3);

        // Fill to full; address must hold once full
        tick(13);
        check("full_addr", 64'(a_addr), 64'd16);
        tick(2);
        check("full_hold_addr", 64'(a_addr),  64'd16);
        check("full_count",     64'(a_count), 64'd6);
        check("full_bytes",     64'(a_bytes), 64'h050403020100);

        // Consume 6 while full: fill resumes only a cycle later
        a_consume = 1'b1; a_len = 3'd6;
        #1 check("full_consume_err", 64'(a_err), 64'd0);
        tick(1);
        a_consume = 1'b0; a_len = '0;
        check("after6_pc",    64'(a_pc),         64'd6);
        check("after6_byte0", 64'(a_bytes[7:0]), 64'h06);
        check("after6_addr",  64'(a_addr),       64'd16);
        tick(1);
        check("resume_addr",  64'(a_addr),       64'd17);

        // Redirect on channels 0 and 1 with a simultaneous consume; channel 1 wins
        a_rvalid = 3'b011;
        a_rpc    = {32'h0, 32'h200, 32'h100};
        a_rmode  = 3'b010;
        a_consume = 1'b1; a_len = 3'd2;
        #1 check("redir_err", 64'(a_err), 64'd0);
        tick(1);
        a_rvalid = '0; a_rpc = '0; a_rmode = '0; a_consume = 1'b0; a_len = '0;
        check("redir_count", 64'(a_count), 64'd0);
        check("redir_pc",    64'(a_pc),    64'h200);
        check("redir_mode",  64'(a_mode),  64'd1);
        check("redir_addr",  64'(a_addr),  64'h200);

        // Consume while empty is illegal
        a_consume = 1'b1; a_len = 3'd1;
        #1 check("empty_err", 64'(a_err), 64'd1);
        tick(1);
        a_consume = 1'b0; a_len = '0;
        check("empty_pc",    64'(a_pc),    64'h200);
        check("empty_count", 64'(a_count), 64'd1);
        tick(2);
        check("win3_count", 64'(a_count), 64'd3);
        check("win3_bytes", 64'(a_bytes), 64'h000000020100);

        // Over-length consume: pulse error, only fill changes state
        a_consume = 1'b1; a_len = 3'd5;
        #1 check("overlen_err", 64'(a_err), 64'd1);
        tick(1);
        a_consume = 1'b0; a_len = '0;
        #1 check("overlen_err_clear", 64'(a_err),   64'd0);
        check("overlen_pc",         64'(a_pc),    64'h200);
        check("overlen_count",      64'(a_count), 64'd4);

        // Legal consume of 2 with concurrent fill
        a_consume = 1'b1; a_len = 3'd2;
        #1 check("len2_err", 64'(a_err), 64'd0);
        tick(1);
        a_consume = 1'b0; a_len = '0;
        check("len2_pc",    64'(a_pc),    64'h202);
        check("len2_count", 64'(a_count), 64'd3);
        check("len2_bytes", 64'(a_bytes), 64'h000000040302);

        // Asynchronous reset with count = 9
        tick(6);
        check("pre_rst_pc", 64'(a_pc), 64'h202);
        #2 reset = 1'b1;
        #1;
        check("async_rst_count", 64'(a_count), 64'd0);
        check("async_rst_pc",    64'(a_pc),    64'h0);
        check("async_rst_addr",  64'(a_addr),  64'h0);
        check("async_rst_mode",  64'(a_mode),  64'd0);
        tick(1);
        reset = 1'b0;

        // Instance B: build 12 bytes, then stream 4-byte consumes across many wraps
        tick(3);
        check("b_prefill_count", 64'(b_count), 64'd6);
        head = 32'h0;
        for (int c = 0; c < 40; c++) begin
            b_consume = 1'b1; b_len = 3'd4;
            for (int k = 0; k < 6; k++) exp_win[8*k +: 8] = 8'(head + 32'(k));
            #1;
            check($sformatf("b_pc_%0d", c),    64'(b_pc),    64'(head));
            check($sformatf("b_bytes_%0d", c), 64'(b_bytes), 64'(exp_win));
            check($sformatf("b_err_%0d", c),   64'(b_err),   64'd0);
            tick(1);
            head = head + 32'd4;
        end
        b_consume = 1'b0; b_len = '0;
        check("b_final_pc",   64'(b_pc),   64'd160);
        check("b_final_addr", 64'(b_addr), 64'd172);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
